mb_qbuf: RTL and testbench

Parametrised memory-buffer block for the MBOX: a WORDS-deep word buffer for block transfers with wrapped word order, plus a channel FIFO with halfword swap. It generalises the fixed four-register MB file and the 128-word channel buffer. Transfer sequencing is hardware-managed through valid/ready handshakes, with NXM zero-fill and overflow status. It sits between the cache/memory data-in muxing and the EBOX/channel consumers.

---
 rtl/mb_qbuf.sv | 245 ++++++++++++++++++++++++
 tb/tb_mb_qbuf.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_qbuf.sv
`default_nettype none
// ============================================================================
// Module   : mb_qbuf
// Purpose  : MBOX memory buffer. Holds a WORDS-deep block buffer that is
//            filled and drained in wrapped word order through valid/ready
//            handshakes, with NXM beats stored as zero. Also holds a channel
//            FIFO that can exchange halfwords on push and flags dropped
//            pushes.
// Ports    : clk, reset_n             - clock, synchronous active-low reset
//            start, start_wd, abort   - block transfer control
//            in_data/in_nxm/in_valid/in_ready     - block write handshake
//            out_data/out_par/out_valid/out_ready - block read handshake
//            busy, word_valid, nxm_err            - block transfer status
//            ch_wr/ch_din/ch_swap/ch_rd/ch_clear  - channel FIFO control
//            ch_dout/ch_full/ch_empty/ch_count/ch_ovf - channel FIFO status
// Revision : 1.0 - initial release
// ============================================================================
module mb_qbuf #(
    parameter int WIDTH    = 36,
    parameter int WORDS    = 4,
    parameter int CH_DEPTH = 128
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [$clog2(WORDS)-1:0]    start_wd,
    input  logic                        abort,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_nxm,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_par,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic [WORDS-1:0]            word_valid,
    output logic                        nxm_err,
    input  logic                        ch_wr,
    input  logic [WIDTH-1:0]            ch_din,
    input  logic                        ch_swap,
    input  logic                        ch_rd,
    input  logic                        ch_clear,
    output logic [WIDTH-1:0]            ch_dout,
    output logic                        ch_full,
    output logic                        ch_empty,
    output logic [$clog2(CH_DEPTH):0]   ch_count,
    output logic                        ch_ovf
);

    localparam int c_aw   = $clog2(WORDS);
    localparam int c_caw  = $clog2(CH_DEPTH);
    localparam int c_half = WIDTH / 2;

    localparam logic [c_aw:0]    c_words    = (c_aw+1)'(WORDS);
    localparam logic [c_aw:0]    c_last     = (c_aw+1)'(WORDS - 1);
    localparam logic [c_aw:0]    c_cnt_one  = (c_aw+1)'(1);
    localparam logic [c_aw-1:0]  c_ptr_one  = c_aw'(1);
    localparam logic [c_caw:0]   c_ch_depth = (c_caw+1)'(CH_DEPTH);
    localparam logic [c_caw:0]   c_ch_one   = (c_caw+1)'(1);
    localparam logic [c_caw-1:0] c_chp_one  = c_caw'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Block buffer
    // ------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_mem [WORDS];
    logic [c_aw-1:0]     r_wr_ptr;
    logic [c_aw-1:0]     r_rd_ptr;
    logic [c_aw:0]       r_loaded;
    logic [c_aw:0]       r_rdcnt;
    logic [WORDS-1:0]    r_word_valid;
    logic                r_nxm_err;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_start_acc;
    logic                w_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake decode depends only on registered state; abort suppresses
    // both accepts so an aborted cycle leaves pointers and slots untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_in_ready  = (r_state == ST_XFER) && (r_loaded < c_words);
        w_out_valid = (r_state == ST_XFER) && r_word_valid[r_rd_ptr];
        w_wr_acc    = in_valid && w_in_ready && !abort;
        w_rd_acc    = w_out_valid && out_ready && !abort;
        w_done      = w_rd_acc && (r_rdcnt == c_last);
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_XFER;
                        w_start_acc = 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_done) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_loaded     <= '0;
            r_rdcnt      <= '0;
            r_word_valid <= '0;
            r_nxm_err    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_mem[r_wr_ptr]        <= in_nxm ? '0 : in_data;
                r_word_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr               <= r_wr_ptr + c_ptr_one;
                r_loaded               <= r_loaded + c_cnt_one;
                if (in_nxm) begin
                    r_nxm_err <= 1'b1;
                end
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                r_rdcnt  <= r_rdcnt + c_cnt_one;
            end
            if (w_start_acc) begin
                r_wr_ptr     <= start_wd;
                r_rd_ptr     <= start_wd;
                r_loaded     <= '0;
                r_rdcnt      <= '0;
                r_word_valid <= '0;
                r_nxm_err    <= 1'b0;
            end
            // Slot data survives the end of a transfer; only the flags drop.
            if (abort || w_done) begin
                r_word_valid <= '0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_par    = ^out_data;
    assign busy       = (r_state == ST_XFER);
    assign word_valid = r_word_valid;
    assign nxm_err    = r_nxm_err;

    // ------------------------------------------------------------------------
    // Channel FIFO
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]    r_ch_mem [CH_DEPTH];
    logic [c_caw-1:0]    r_ch_wr_ptr;
    logic [c_caw-1:0]    r_ch_rd_ptr;
    logic [c_caw:0]      r_ch_count;
    logic [WIDTH-1:0]    r_ch_dout;
    logic                r_ch_ovf;

    logic                w_ch_full;
    logic                w_ch_empty;
    logic                w_ch_push;
    logic                w_ch_pop;
    logic                w_ch_ovf_set;
    logic [WIDTH-1:0]    w_ch_wdata;

    assign w_ch_full    = (r_ch_count == c_ch_depth);
    assign w_ch_empty   = (r_ch_count == '0);
    assign w_ch_pop     = ch_rd && !w_ch_empty && !ch_clear;
    // When full, a same-cycle pop frees the slot, so the push still lands.
    assign w_ch_push    = ch_wr && (!w_ch_full || ch_rd) && !ch_clear;
    assign w_ch_ovf_set = ch_wr && w_ch_full && !ch_rd && !ch_clear;
    assign w_ch_wdata   = ch_swap ? {ch_din[c_half-1:0], ch_din[WIDTH-1:c_half]}
                                  : ch_din;

    // Storage array carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_ch_push) begin
            r_ch_mem[r_ch_wr_ptr] <= w_ch_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ch_wr_ptr <= '0;
            r_ch_rd_ptr <= '0;
            r_ch_count  <= '0;
            r_ch_dout   <= '0;
            r_ch_ovf    <= 1'b0;
        end else if (ch_clear) begin
            r_ch_wr_ptr <= '0;
            r_ch_rd_ptr <= '0;
            r_ch_count  <= '0;
            r_ch_ovf    <= 1'b0;
        end else begin
            if (w_ch_push) begin
                r_ch_wr_ptr <= r_ch_wr_ptr + c_chp_one;
            end
            if (w_ch_pop) begin
                r_ch_rd_ptr <= r_ch_rd_ptr + c_chp_one;
                r_ch_dout   <= r_ch_mem[r_ch_rd_ptr];
            end
            case ({w_ch_push, w_ch_pop})
                2'b10:   r_ch_count <= r_ch_count + c_ch_one;
                2'b01:   r_ch_count <= r_ch_count - c_ch_one;
                default: r_ch_count <= r_ch_count;
            endcase
            if (w_ch_ovf_set) begin
                r_ch_ovf <= 1'b1;
            end
        end
    end

    assign ch_dout  = r_ch_dout;
    assign ch_full  = w_ch_full;
    assign ch_empty = w_ch_empty;
    assign ch_count = r_ch_count;
    assign ch_ovf   = r_ch_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mb_qbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_mb_qbuf
// Purpose  : Directed self-checking bench for mb_qbuf (WORDS=4, CH_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mb_qbuf;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  start_wd;
    logic        abort;
    logic [35:0] in_data;
    logic        in_nxm;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] out_data;
    logic        out_par;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [3:0]  word_valid;
    logic        nxm_err;
    logic        ch_wr;
    logic [35:0] ch_din;
    logic        ch_swap;
    logic        ch_rd;
    logic        ch_clear;
    logic [35:0] ch_dout;
    logic        ch_full;
    logic        ch_empty;
    logic [2:0]  ch_count;
    logic        ch_ovf;

    int n_checks = 0;
    int n_errors = 0;

    mb_qbuf #(.WIDTH(36), .WORDS(4), .CH_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_wd   (start_wd),
        .abort      (abort),
        .in_data    (in_data),
        .in_nxm     (in_nxm),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_par    (out_par),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .word_valid (word_valid),
        .nxm_err    (nxm_err),
        .ch_wr      (ch_wr),
        .ch_din     (ch_din),
        .ch_swap    (ch_swap),
        .ch_rd      (ch_rd),
        .ch_clear   (ch_clear),
        .ch_dout    (ch_dout),
        .ch_full    (ch_full),
        .ch_empty   (ch_empty),
        .ch_count   (ch_count),
        .ch_ovf     (ch_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [35:0] a_words [4];
    logic        a_par   [4];
    logic [35:0] b_words [4];
    logic [35:0] d_words [6];
    logic [35:0] d_exp   [4];

    initial begin
        a_words = '{36'h1_2345_6789, 36'hF_0F0F_0F0E, 36'h0_0000_0001, 36'hA_5A5A_5A5A};
        a_par   = '{1'b1, 1'b1, 1'b1, 1'b0};
        b_words = '{36'h0_0000_0123, 36'o777777777777, 36'h0_0000_0456, 36'h0_0000_0789};
        d_words = '{36'h1_0000_0001, 36'h2_0000_0002, 36'h3_0000_0003,
                    36'h4_0000_0004, 36'h5_0000_0005, 36'h6_0000_0006};
        d_exp   = '{36'h2_0000_0002, 36'h3_0000_0003, 36'h4_0000_0004, 36'h6_0000_0006};

        reset_n = 1'b0; start = 1'b0; start_wd = 2'd0; abort = 1'b0;
        in_data = '0; in_nxm = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ch_wr = 1'b0; ch_din = '0; ch_swap = 1'b0; ch_rd = 1'b0; ch_clear = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state
        check("rst_busy",     busy,       0);
        check("rst_wvalid",   word_valid, 0);
        check("rst_nxm",      nxm_err,    0);
        check("rst_ovalid",   out_valid,  0);
        check("rst_odata",    out_data,   0);
        check("rst_ch_empty", ch_empty,   1);
        check("rst_ch_count", ch_count,   0);
        check("rst_ch_dout",  ch_dout,    0);

        // Wrapped fill from slot 2, streaming
        start = 1'b1; start_wd = 2'd2;
        tick();
        start = 1'b0;
        check("fill_busy",   busy,      1);
        check("fill_iready", in_ready,  1);
        check("fill_ovalid0", out_valid, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = a_words[i];
            tick();
            check("fill_ovalid", out_valid, 1);
            check("fill_odata",  out_data,  a_words[i]);
            check("fill_par",    out_par,   a_par[i]);
            if (i == 0) check("fill_wv0", word_valid, 4'b0100);
        end
        in_valid = 1'b0;
        check("fill_busy4", busy, 1);
        tick();
        check("fill_idle",   busy,       0);
        check("fill_wv_clr", word_valid, 0);
        check("fill_odata0", out_data,   0);

        // NXM beat with backpressure
        out_ready = 1'b0;
        start = 1'b1; start_wd = 2'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = b_words[i]; in_nxm = (i == 1);
            tick();
            if (i == 2) check("bp_iready3", in_ready, 1);
        end
        in_valid = 1'b0; in_nxm = 1'b0;
        check("bp_iready4", in_ready,   0);
        check("nxm_set",    nxm_err,    1);
        check("bp_ovalid",  out_valid,  1);
        check("bp_odata",   out_data,   36'h0_0000_0123);
        check("bp_wv",      word_valid, 4'b1111);
        tick();
        check("bp_hold",    out_data,   36'h0_0000_0123);
        out_ready = 1'b1;
        tick();
        check("nxm_ovalid", out_valid, 1);
        check("nxm_zero",   out_data,  0);
        check("nxm_par",    out_par,   0);
        tick();
        check("bp_d2", out_data, 36'h0_0000_0456);
        tick();
        check("bp_d3", out_data, 36'h0_0000_0789);
        tick();
        check("bp_idle", busy, 0);
        check("nxm_sticky", nxm_err, 1);
        start = 1'b1; start_wd = 2'd0;
        tick();
        start = 1'b0;
        check("nxm_clr", nxm_err, 0);
        check("nxm_busy", busy, 1);

        // Abort colliding with start and a write
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 36'h0_0000_0ABC;
        tick();
        check("ab_wv", word_valid, 4'b0001);
        abort = 1'b1; start = 1'b1; start_wd = 2'd3;
        tick();
        abort = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("ab_idle",   busy,       0);
        check("ab_wv_clr", word_valid, 0);
        check("ab_ovalid", out_valid,  0);
        start = 1'b1; start_wd = 2'd1;
        tick();
        start = 1'b0;
        check("ab_restart", busy,       1);
        check("ab_iready",  in_ready,   1);
        check("ab_wv0",     word_valid, 0);
        // start in XFER is ignored; the write lands in slot 1
        start = 1'b1; start_wd = 2'd3; in_valid = 1'b1; in_data = 36'h0_0000_0DEF;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("ign_wv",    word_valid, 4'b0010);
        check("ign_odata", out_data,   36'h0_0000_0DEF);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // FIFO full / overflow
        for (int i = 0; i < 5; i++) begin
            ch_wr = 1'b1; ch_din = d_words[i];
            tick();
            if (i < 4) check("ff_count", ch_count, i + 1);
            if (i == 3) check("ff_ovf0", ch_ovf, 0);
        end
        check("ff_full",   ch_full,  1);
        check("ff_count4", ch_count, 4);
        check("ff_ovf",    ch_ovf,   1);
        ch_wr = 1'b1; ch_rd = 1'b1; ch_din = d_words[5];
        tick();
        ch_wr = 1'b0; ch_rd = 1'b0;
        check("ff_pp_count", ch_count, 4);
        check("ff_pp_dout",  ch_dout,  36'h1_0000_0001);
        for (int i = 0; i < 4; i++) begin
            ch_rd = 1'b1;
            tick();
            check("ff_pop", ch_dout, d_exp[i]);
        end
        ch_rd = 1'b0;
        check("ff_empty",      ch_empty, 1);
        check("ff_ovf_sticky", ch_ovf,   1);
        ch_clear = 1'b1;
        tick();
        ch_clear = 1'b0;
        check("ff_clr_ovf",  ch_ovf,  0);
        check("ff_clr_dout", ch_dout, 36'h6_0000_0006);

        // Swap and empty pop
        ch_wr = 1'b1; ch_swap = 1'b1; ch_din = 36'o123456654321;
        tick();
        ch_wr = 1'b0; ch_swap = 1'b0;
        check("sw_count", ch_count, 1);
        ch_rd = 1'b1;
        tick();
        ch_rd = 1'b0;
        check("sw_dout",  ch_dout,  36'o654321123456);
        check("sw_empty", ch_empty, 1);
        ch_rd = 1'b1;
        tick();
        ch_rd = 1'b0;
        check("ep_dout",  ch_dout,  36'o654321123456);
        check("ep_count", ch_count, 0);

        // Push and pop together on empty: only the push happens
        ch_wr = 1'b1; ch_rd = 1'b1; ch_din = 36'h0_0000_0077;
        tick();
        ch_wr = 1'b0; ch_rd = 1'b0;
        check("pe_count", ch_count, 1);
        check("pe_dout",  ch_dout,  36'o654321123456);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
